mmio_port_responder: RTL

- Memory-mapped I/O responder on the MIPS core's data-bus side; it is the target end of the core's load/store accesses.
- Owns the output port register and a synchronised input port with a sticky change flag.
- Owns a byte transmit FIFO drained to an external consumer over a valid/ready handshake.
- Sits beside DataMemory behind the core's address decode. It answers core requests with a Ready handshake and inserts wait states when the FIFO is full.

---
 rtl/mmio_port_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mmio_port_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmio_port_responder                                                      |
// | Data-bus MMIO target: output port, synchronised input port, TX byte FIFO |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mmio_port_responder #(
   parameter int FIFO_DEPTH    = 4,
   parameter int PORT_IN_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     Sel,
   input  logic                     MemRead,
   input  logic                     MemWrite,
   input  logic [31:0]              Address,
   input  logic [31:0]              WriteData,
   output logic [31:0]              ReadData,
   output logic                     Ready,
   input  logic [PORT_IN_WIDTH-1:0] PortIn,
   output logic [31:0]              PortOut,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready
);

   localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int                 c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] c_REG_PORT_OUT = 2'd0;
   localparam logic [1:0] c_REG_PORT_IN  = 2'd1;
   localparam logic [1:0] c_REG_STATUS   = 2'd2;
   localparam logic [1:0] c_REG_TX_DATA  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACK  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t                     r_state;
   logic [31:0]                r_read_data;
   logic                       r_ready;
   logic [31:0]                r_port_out;
   logic [PORT_IN_WIDTH-1:0]   r_sync1;
   logic [PORT_IN_WIDTH-1:0]   r_sync2;
   logic [PORT_IN_WIDTH-1:0]   r_prev;
   logic                       r_in_changed;
   logic [7:0]                 r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]         r_rd_ptr;
   logic [c_PTR_W-1:0]         r_wr_ptr;
   logic [c_CNT_W-1:0]         r_count;

   logic        w_req;
   logic        w_is_wr;
   logic        w_is_rd;
   logic [1:0]  w_addr;
   logic        w_full;
   logic        w_empty;
   logic        w_pop;
   logic        w_can_push;
   logic        w_tx_wr;
   logic        w_sample;
   logic        w_push;
   logic        w_clr;
   logic [31:0] w_rdata;
   logic        w_unused;

   assign w_unused = &{1'b0, Address[31:4], Address[1:0]};

   always_comb begin
      w_req      = Sel & (MemRead | MemWrite);
      w_is_wr    = Sel & MemWrite;
      w_is_rd    = Sel & MemRead & ~MemWrite;
      w_addr     = Address[3:2];
      w_full     = (r_count == c_DEPTH);
      w_empty    = (r_count == '0);
      w_pop      = ~w_empty & tx_ready;
      w_can_push = ~w_full | w_pop;
      w_tx_wr    = w_is_wr & (w_addr == c_REG_TX_DATA);
      w_sample   = (r_state == S_IDLE) | (r_state == S_WAIT);
      w_push     = w_sample & w_tx_wr & w_can_push;
      w_clr      = (r_state == S_IDLE) & w_is_wr & (w_addr == c_REG_STATUS) & WriteData[0];
      w_rdata    = 32'd0;
      case (w_addr)
         c_REG_PORT_OUT: w_rdata = r_port_out;
         c_REG_PORT_IN:  w_rdata = 32'(r_sync2);
         c_REG_STATUS:   w_rdata = {29'd0, w_empty, w_full, r_in_changed};
         default:        w_rdata = 32'd0;
      endcase
   end

   assign ReadData = r_read_data;
   assign Ready    = r_ready;
   assign PortOut  = r_port_out;
   assign tx_valid = ~w_empty;
   assign tx_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];

   // A fresh edge seen in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1      <= '0;
         r_sync2      <= '0;
         r_prev       <= '0;
         r_in_changed <= 1'b0;
      end else begin
         r_sync1 <= PortIn;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         if (r_sync2 != r_prev)
            r_in_changed <= 1'b1;
         else if (w_clr)
            r_in_changed <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            r_mem[i] <= 8'h00;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= WriteData[7:0];
            r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_ready     <= 1'b0;
         r_read_data <= 32'd0;
         r_port_out  <= 32'd0;
      end else begin
         r_ready     <= 1'b0;
         r_read_data <= 32'd0;
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  if (w_tx_wr && !w_can_push) begin
                     r_state <= S_WAIT;
                  end else begin
                     r_state     <= S_ACK;
                     r_ready     <= 1'b1;
                     r_read_data <= w_is_rd ? w_rdata : 32'd0;
                     if (w_is_wr && (w_addr == c_REG_PORT_OUT))
                        r_port_out <= WriteData;
                  end
               end
            end
            S_WAIT: begin
               if (!(w_req && w_tx_wr)) begin
                  r_state <= S_IDLE;
               end else if (w_can_push) begin
                  r_state <= S_ACK;
                  r_ready <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
